// File: rtl/cache_refill_ctrl.sv
// Miss/refill and write-through sequencer for a 16-set direct-mapped cache with 4-word lines.
// Load misses fetch the block word by word, then write the assembled line in one cycle.
module cache_refill_ctrl #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int BLOCK_WORDS = 4,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              cpu_req,
   input  logic                              cpu_we,
   input  logic [1:0]                        cpu_size,
   input  logic [ADDR_WIDTH-1:0]             cpu_addr,
   input  logic [DATA_WIDTH-1:0]             cpu_wdata,
   input  logic                              cache_hit,
   output logic                              stall,
   output logic                              mem_req,
   output logic                              mem_we,
   output logic [1:0]                        mem_size,
   output logic [ADDR_WIDTH-1:0]             mem_addr,
   output logic [DATA_WIDTH-1:0]             mem_wdata,
   input  logic                              mem_ack,
   input  logic [DATA_WIDTH-1:0]             mem_rdata,
   output logic                              fill_we,
   output logic [3:0]                        fill_index,
   output logic [ADDR_WIDTH-9:0]             fill_tag,
   output logic [BLOCK_WORDS*DATA_WIDTH-1:0] fill_line,
   output logic [CNT_WIDTH-1:0]              hit_count,
   output logic [CNT_WIDTH-1:0]              miss_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REFILL,
      S_FILL,
      S_WRITE,
      S_RESUME
   } state_t;

   state_t                             state_q, state_d;
   logic [1:0]                         word_cnt_q;
   logic [ADDR_WIDTH-1:0]              addr_q;
   logic [DATA_WIDTH-1:0]              wdata_q;
   logic [1:0]                         size_q;
   logic [BLOCK_WORDS*DATA_WIDTH-1:0]  line_q;
   logic [CNT_WIDTH-1:0]               hit_cnt_q;
   logic [CNT_WIDTH-1:0]               miss_cnt_q;

   logic load_hit, load_miss, store_acc, last_word;

   assign load_hit  = cpu_req & ~cpu_we & cache_hit;
   assign load_miss = cpu_req & ~cpu_we & ~cache_hit;
   assign store_acc = cpu_req & cpu_we;
   assign last_word = (word_cnt_q == 2'(BLOCK_WORDS - 1));

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      stall    = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      mem_size = 2'b00;
      mem_addr = '0;
      fill_we  = 1'b0;
      case (state_q)
         S_IDLE: begin
            stall = cpu_req & (cpu_we | ~cache_hit);
            if (store_acc)      state_d = S_WRITE;
            else if (load_miss) state_d = S_REFILL;
         end
         S_REFILL: begin
            stall    = 1'b1;
            mem_req  = 1'b1;
            mem_addr = {addr_q[ADDR_WIDTH-1:4], word_cnt_q, 2'b00};
            if (mem_ack && last_word) state_d = S_FILL;
         end
         S_FILL: begin
            stall   = 1'b1;
            fill_we = 1'b1;
            state_d = S_RESUME;
         end
         S_WRITE: begin
            stall    = 1'b1;
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            mem_size = size_q;
            mem_addr = addr_q;
            if (mem_ack) state_d = S_RESUME;
         end
         S_RESUME: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Datapath registers; only IDLE samples the cpu_* inputs, so they may change freely while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_cnt_q <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         size_q     <= '0;
         line_q     <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (store_acc) begin
                  addr_q  <= cpu_addr;
                  wdata_q <= cpu_wdata;
                  size_q  <= (cpu_size == 2'b11) ? 2'b00 : cpu_size;
               end else if (load_miss) begin
                  addr_q     <= cpu_addr;
                  word_cnt_q <= '0;
                  if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
               end else if (load_hit) begin
                  if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
               end
            end
            S_REFILL: begin
               if (mem_ack) begin
                  for (int i = 0; i < BLOCK_WORDS; i++) begin
                     if (word_cnt_q == i[1:0])
                        line_q[i*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
                  end
                  if (!last_word) word_cnt_q <= word_cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_wdata  = wdata_q;
   assign fill_index = addr_q[7:4];
   assign fill_tag   = addr_q[ADDR_WIDTH-1:8];
   assign fill_line  = line_q;
   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: misses, hits, stores, delayed acks, reset abort, saturation.
module tb_cache_refill_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         cpu_req, cpu_we, cache_hit, mem_ack;
   logic [1:0]   cpu_size;
   logic [31:0]  cpu_addr, cpu_wdata, mem_rdata;
   logic         stall, mem_req, mem_we, fill_we;
   logic [1:0]   mem_size;
   logic [31:0]  mem_addr, mem_wdata, hit_count, miss_count;
   logic [3:0]   fill_index;
   logic [23:0]  fill_tag;
   logic [127:0] fill_line;

   int checks   = 0;
   int failures = 0;
   int stall_cnt;

   cache_refill_ctrl dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cache_hit(cache_hit),
      .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .fill_we(fill_we), .fill_index(fill_index), .fill_tag(fill_tag), .fill_line(fill_line),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Memory responder for nw words: delay d[k] idle cycles with req held, then a one-cycle ack.
   task automatic refill(input logic [31:0] base, input int d0, input int d1, input int d2,
                         input int d3, input logic [31:0] dbase, input int nw);
      int dl[4];
      dl = '{d0, d1, d2, d3};
      for (int k = 0; k < nw; k++) begin
         for (int w = 0; w < dl[k]; w++) begin
            mem_ack = 1'b0;
            #1;
            chk("refill_wait_req", 32'(mem_req), 32'd1);
            chk("refill_wait_addr", mem_addr, base + 32'(4 * k));
            stall_cnt += int'(stall);
            step();
         end
         mem_ack   = 1'b1;
         mem_rdata = dbase + 32'(k);
         #1;
         chk("refill_ack_addr", mem_addr, base + 32'(4 * k));
         chk("refill_ack_we", 32'(mem_we), 32'd0);
         stall_cnt += int'(stall);
         step();
         mem_ack   = 1'b0;
         mem_rdata = 32'h0;
      end
   endtask

   task automatic issue_load(input logic [31:0] addr);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b00; cpu_addr = addr; cache_hit = 1'b0;
      #1;
      chk("load_miss_idle_stall", 32'(stall), 32'd1);
      step();
      cpu_req = 1'b0; cpu_addr = 32'hDEAD_BEEC;
      stall_cnt = 0;
   endtask

   initial begin
      rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'b00; cpu_addr = 32'h0;
      cpu_wdata = 32'h0; cache_hit = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
      step(); step();
      rst = 1'b0;
      #1;
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_fill_we", 32'(fill_we), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_hit", hit_count, 32'h0);
      chk("rst_miss", miss_count, 32'h0);
      chkw("rst_line", fill_line, 128'h0);

      // Three consecutive load hits.
      for (int i = 0; i < 3; i++) begin
         cpu_req = 1'b1; cpu_we = 1'b0; cache_hit = 1'b1; cpu_addr = 32'h100 + 32'(4 * i);
         #1;
         chk("hit_stall", 32'(stall), 32'd0);
         chk("hit_mem_req", 32'(mem_req), 32'd0);
         step();
      end
      cpu_req = 1'b0; cache_hit = 1'b0;
      #1;
      chk("hit_count3", hit_count, 32'd3);

      // Stray ack with no request outstanding.
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      #1;
      chk("stray_ack_req", 32'(mem_req), 32'd0);
      chk("stray_ack_stall", 32'(stall), 32'd0);

      // Load miss, ack one cycle after each request.
      issue_load(32'h0001_0040);
      refill(32'h0001_0040, 1, 1, 1, 1, 32'h0000_00A0, 4);
      #1;
      stall_cnt += int'(stall);
      chk("t1_fill_we", 32'(fill_we), 32'd1);
      chk("t1_index", 32'(fill_index), 32'd4);
      chk("t1_tag", 32'(fill_tag), 32'h0000_0100);
      chkw("t1_line", fill_line, 128'h000000A3_000000A2_000000A1_000000A0);
      chk("t1_miss", miss_count, 32'd1);
      step();
      #1;
      chk("t1_stall_cycles", 32'(stall_cnt), 32'd9);
      chk("t1_resume_stall", 32'(stall), 32'd0);
      chk("t1_resume_fill_we", 32'(fill_we), 32'd0);
      step();

      // Byte store, ack after two waits; cpu inputs scrambled while stalled.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'b01; cpu_addr = 32'h0001_0007;
      cpu_wdata = 32'h0000_00EF;
      #1;
      chk("st_idle_stall", 32'(stall), 32'd1);
      step();
      cpu_req = 1'b0; cpu_size = 2'b10; cpu_addr = 32'h1234_5678; cpu_wdata = 32'h5555_5555;
      for (int i = 0; i < 3; i++) begin
         mem_ack = (i == 2);
         #1;
         chk("st_req", 32'(mem_req), 32'd1);
         chk("st_we", 32'(mem_we), 32'd1);
         chk("st_size", 32'(mem_size), 32'd1);
         chk("st_addr", mem_addr, 32'h0001_0007);
         chk("st_wdata", mem_wdata, 32'h0000_00EF);
         step();
      end
      mem_ack = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cache_hit = 1'b1;
      #1;
      chk("st_resume_stall", 32'(stall), 32'd0);
      chk("st_resume_req", 32'(mem_req), 32'd0);
      step();
      cpu_req = 1'b0; cache_hit = 1'b0;
      #1;
      chk("resume_load_not_counted", hit_count, 32'd3);

      // Store with size 11 goes out as a word; zero-wait ack.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'b11; cpu_addr = 32'h0002_0000;
      cpu_wdata = 32'hCAFE_F00D;
      step();
      cpu_req = 1'b0; mem_ack = 1'b1;
      #1;
      chk("st11_size", 32'(mem_size), 32'd0);
      chk("st11_wdata", mem_wdata, 32'hCAFE_F00D);
      step();
      mem_ack = 1'b0;
      step();

      // Refill with uneven ack delays.
      issue_load(32'h00AB_CD70);
      refill(32'h00AB_CD70, 0, 5, 0, 2, 32'hB000_0000, 4);
      #1;
      chk("t4_fill_we", 32'(fill_we), 32'd1);
      chk("t4_index", 32'(fill_index), 32'd7);
      chk("t4_tag", 32'(fill_tag), 32'h0000_ABCD);
      chkw("t4_line", fill_line, 128'hB0000003_B0000002_B0000001_B0000000);
      chk("t4_miss", miss_count, 32'd2);
      step(); step();

      // Reset after the second ack aborts the refill without a fill.
      issue_load(32'h0003_0080);
      refill(32'h0003_0080, 1, 1, 0, 0, 32'h0000_00C0, 2);
      rst = 1'b1;
      #1;
      chk("t5_fill_we_pre", 32'(fill_we), 32'd0);
      step();
      rst = 1'b0;
      #1;
      chk("t5_req", 32'(mem_req), 32'd0);
      chk("t5_fill_we", 32'(fill_we), 32'd0);
      chk("t5_stall", 32'(stall), 32'd0);
      chkw("t5_line", fill_line, 128'h0);
      chk("t5_miss", miss_count, 32'd0);
      chk("t5_tag", 32'(fill_tag), 32'd0);
      issue_load(32'h0003_0080);
      refill(32'h0003_0080, 1, 1, 1, 1, 32'h0000_00C0, 4);
      #1;
      chk("t5_fill_we_after", 32'(fill_we), 32'd1);
      chkw("t5_line_after", fill_line, 128'h000000C3_000000C2_000000C1_000000C0);
      chk("t5_miss_after", miss_count, 32'd1);
      step(); step();

      // Saturated miss counter holds.
      force dut.miss_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.miss_cnt_q;
      #1;
      chk("t6_preload", miss_count, 32'hFFFF_FFFF);
      issue_load(32'h0005_0000);
      chk("t6_sat_refill", miss_count, 32'hFFFF_FFFF);
      refill(32'h0005_0000, 0, 0, 0, 0, 32'h0000_00D0, 4);
      step(); step();
      #1;
      chk("t6_sat_end", miss_count, 32'hFFFF_FFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
